mem_copy_engine: RTL and testbench

Bus-master DMA engine that drives the fast memory's address/in/load port and consumes its registered read data. It performs block copies (src→dst) and block fills (constant→dst) over the 0x0000–0x6000 address window. Software or the CPU's control logic issues a single start pulse, and the engine reports completion with a one-cycle done pulse. It sits between the CPU-side control path and the fast memory port, which it owns while busy.

---
 rtl/mem_copy_engine.sv | 138 +++++++++++++
 tb/tb_mem_copy_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA bus master for the fast memory port.
// Performs block copies (src -> dst) and block fills (constant -> dst)
// inside the 0..MEM_TOP window. It takes a one-cycle start pulse and
// reports completion with a one-cycle done pulse. err reports the most
// recent rejected request.
//
// Handshake: start is a request pulse that is honoured only while the
// engine is in IDLE. It is ignored in every other state, and no ready
// signal is returned. Each accepted or rejected request produces exactly
// one done pulse. A copy word is read in RD. The memory returns registered
// data during the following WR cycle, and the engine forwards that data
// combinationally onto mem_in.
module mem_copy_engine #(
    parameter int                 ADDR_W  = 15,
    parameter int                 DATA_W  = 16,
    parameter logic [ADDR_W-1:0]  MEM_TOP = 15'h6000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] fill_q;

    logic [15:0] dst_end;
    logic [15:0] src_end;
    logic        reject;

    // Bounds check on the incoming request. The check uses 16-bit sums so
    // that the last address cannot wrap past the window.
    assign dst_end = 16'(dst) + 16'(len) - 16'd1;
    assign src_end = 16'(src) + 16'(len) - 16'd1;
    assign reject  = (len == '0) || (dst_end > 16'(MEM_TOP)) ||
                     (!mode && (src_end > 16'(MEM_TOP)));

    // Write data is the fill word, or the memory's registered read data
    // passed straight through while in a copy WR cycle.
    always_comb begin
        mem_in = '0;
        if (state == WR) mem_in = mode_q ? fill_q : mem_out;
    end

    // Control FSM. Port outputs are registered alongside the state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            cnt         <= '0;
            fill_q      <= '0;
            mem_address <= '0;
            mem_load    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q  <= mode;
                        src_ptr <= src;
                        dst_ptr <= dst;
                        cnt     <= len;
                        fill_q  <= fill_value;
                        err     <= 1'b0;
                        if (reject) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (mode) begin
                            state       <= WR;
                            busy        <= 1'b1;
                            mem_address <= dst;
                            mem_load    <= 1'b1;
                        end else begin
                            state       <= RD;
                            busy        <= 1'b1;
                            mem_address <= src;
                            mem_load    <= 1'b0;
                        end
                    end
                end
                RD: begin
                    state       <= WR;
                    mem_address <= dst_ptr;
                    mem_load    <= 1'b1;
                end
                WR: begin
                    src_ptr <= src_ptr + ONE;
                    dst_ptr <= dst_ptr + ONE;
                    cnt     <= cnt - ONE;
                    if (cnt == ONE) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        mem_load    <= 1'b0;
                        mem_address <= '0;
                    end else if (mode_q) begin
                        mem_address <= dst_ptr + ONE;
                    end else begin
                        state       <= RD;
                        mem_address <= src_ptr + ONE;
                        mem_load    <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: it contains a behavioural fast memory, a
// reference memory, and a write scoreboard with done/err/busy timing checks.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [14:0] src;
    logic [14:0] dst;
    logic [14:0] len;
    logic [15:0] fill_value;
    logic [15:0] mem_out;
    logic [14:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    mem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src),
        .dst(dst), .len(len), .fill_value(fill_value), .mem_out(mem_out),
        .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
        .busy(busy), .done(done), .err(err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // fast memory model: registered read, write on mem_load
    always @(posedge clk) begin
        if (mem_load) mem[mem_address] <= mem_in;
        mem_out <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // write monitor: every memory write must match the next expected write
    always @(negedge clk) begin
        if (rst_n && mem_load) begin
            chk("wr_busy", {31'd0, busy}, 32'd1);
            if (exp_q.size() == 0) chk("unexp_wr", {1'b0, mem_address, mem_in}, 32'hFFFF_FFFF);
            else chk("wr", {1'b0, mem_address, mem_in}, exp_q.pop_front());
        end
    end

    // driver: pulse start with the given arguments; return just after E0
    task automatic issue(input logic m, input int s, input int d, input int l, input logic [15:0] fv);
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; src = 15'(s); dst = 15'(d); len = 15'(l); fill_value = fv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // wait for done; optionally poke a competing start in cycle poke_cyc
    task automatic wait_done(input int exp_cyc, input logic exp_err, input int exp_busy, input int poke_cyc);
        int  cyc    = 0;
        int  busy_n = 0;
        bit  seen   = 0;
        while (!seen && cyc < exp_cyc + 10) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (done) seen = 1;
            if (cyc == poke_cyc) begin
                start = 1'b1; mode = 1'b0; src = 15'h0010; dst = 15'h0400; len = 15'd2;
                fill_value = 16'h1234;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_cyc", cyc, exp_cyc);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("busy_cyc", busy_n, exp_busy);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("err_hold", {31'd0, err}, {31'd0, exp_err});
    endtask

    // scoreboard feed: model the transfer on ref_mem, queue expected writes
    task automatic run(input logic m, input int s, input int d, input int l,
                       input logic [15:0] fv, input int poke_cyc);
        bit ok;
        logic [15:0] w;
        ok = (l != 0) && (d + l - 1 <= 'h6000) && (m || (s + l - 1 <= 'h6000));
        if (ok) begin
            for (int i = 0; i < l; i++) begin
                w = m ? fv : ref_mem[s + i];
                ref_mem[d + i] = w;
                exp_q.push_back({1'b0, 15'(d + i), w});
            end
        end
        issue(m, s, d, l, fv);
        if (ok) wait_done(m ? l + 1 : 2 * l + 1, 1'b0, m ? l : 2 * l, poke_cyc);
        else    wait_done(1, 1'b1, 0, poke_cyc);
        chk("q_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_value = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        mem[16'h0010] = 16'h1111; ref_mem[16'h0010] = 16'h1111;
        mem[16'h0011] = 16'h2222; ref_mem[16'h0011] = 16'h2222;
        mem[16'h0012] = 16'h3333; ref_mem[16'h0012] = 16'h3333;
        mem[16'h0020] = 16'hAAAA; ref_mem[16'h0020] = 16'hAAAA;
        mem[16'h0021] = 16'hBBBB; ref_mem[16'h0021] = 16'hBBBB;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_load", {31'd0, mem_load}, 32'd0);
        chk("rst_addr", {17'd0, mem_address}, 32'd0);
        chk("rst_in", {16'd0, mem_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill
        run(1'b1, 0, 'h0100, 4, 16'hBEEF, 0);
        for (int a = 'h0100; a <= 'h0103; a++) chk("fill_rd", {16'd0, mem[a]}, 32'h0000_BEEF);
        chk("fill_below", {16'd0, mem[16'h00FF]}, 32'd0);
        chk("fill_above", {16'd0, mem[16'h0104]}, 32'd0);

        // copy
        run(1'b0, 'h0010, 'h0200, 3, 16'h0, 0);
        chk("copy_rd0", {16'd0, mem[16'h0200]}, 32'h1111);
        chk("copy_rd1", {16'd0, mem[16'h0201]}, 32'h2222);
        chk("copy_rd2", {16'd0, mem[16'h0202]}, 32'h3333);

        // bounds
        run(1'b1, 0, 'h5FFF, 2, 16'hC0DE, 0);
        chk("top_word", {16'd0, mem[16'h6000]}, 32'h0000_C0DE);
        run(1'b1, 0, 'h5FFF, 3, 16'hDEAD, 0);
        run(1'b1, 0, 'h0100, 0, 16'hDEAD, 0);
        run(1'b0, 'h5FFF, 'h0000, 3, 16'h0, 0);

        // overlap, propagating copy
        run(1'b0, 'h0020, 'h0021, 2, 16'h0, 0);
        chk("ovl_21", {16'd0, mem[16'h0021]}, 32'h0000_AAAA);
        chk("ovl_22", {16'd0, mem[16'h0022]}, 32'h0000_AAAA);

        // start while busy is ignored
        run(1'b1, 0, 'h0300, 8, 16'h5A5A, 3);
        chk("poke_nowr", {16'd0, mem[16'h0400]}, 32'd0);

        // random small transfers
        for (int k = 0; k < 4; k++) begin
            int rl = $urandom_range(1, 6);
            int rd = $urandom_range('h1000, 'h1FF0);
            int rs = $urandom_range('h0010, 'h0014);
            logic rm = 1'($urandom_range(0, 1));
            run(rm, rs, rd, rl, 16'($urandom_range(0, 65535)), 0);
        end

        // reset during the second WR of a len=5 copy
        ref_mem[16'h0500] = 16'h1111;
        exp_q.push_back({1'b0, 15'h0500, 16'h1111});
        issue(1'b0, 'h0010, 'h0500, 5, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_load", {31'd0, mem_load}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_addr", {17'd0, mem_address}, 32'd0);
        chk("mr_in", {16'd0, mem_in}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr_q", exp_q.size(), 0);
        chk("mr_w0", {16'd0, mem[16'h0500]}, 32'h1111);
        chk("mr_w1", {16'd0, mem[16'h0501]}, 32'd0);
        run(1'b1, 0, 'h0600, 3, 16'h7777, 0);
        chk("post_fill", {16'd0, mem[16'h0602]}, 32'h7777);

        // whole reference image of touched regions
        for (int a = 'h0000; a < 'h0700; a++) chk("ref_cmp", {16'd0, mem[a]}, {16'd0, ref_mem[a]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
